// File: rtl/uart_tx_engine.sv
// UART transmit engine: captures a character on load and serialises start, data, parity
// and stop bits onto tx, advancing one bit per shift strobe from an external baud counter.
module uart_tx_engine #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       shift,
    output logic       shifting,
    output logic       tx,
    output logic       tx_rdy,
    output logic       done
);

    localparam int unsigned N    = 11 + STOP_BITS - 1;
    localparam logic [3:0]  LAST = 4'(N - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   frame_q, frame_d;
    logic           tx_q, tx_d;
    logic           done_q, done_d;

    logic [7:0]     data_used;
    logic           par_bit;
    logic [N-1:0]   frame_new;

    // Frame image as it will appear on the line, bit 0 (start) first.
    always_comb begin
        data_used    = eight ? data : {1'b0, data[6:0]};
        par_bit      = pen ? ((^data_used) ^ ohel) : 1'b1;
        frame_new    = '1;
        frame_new[0] = 1'b0;
        frame_new[7:1] = data[6:0];
        frame_new[8] = eight ? data[7] : par_bit;
        frame_new[9] = eight ? par_bit : 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        shifting = (state_q == StShift);
        tx_rdy   = (state_q == StIdle);
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StShift;
                    cnt_d   = 4'd0;
                    frame_d = frame_new;
                    tx_d    = 1'b0;
                end
            end
            StShift: begin
                if (shift) begin
                    if (cnt_q == LAST) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                        frame_d = '1;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // frame_q[0] is always the bit currently on the line.
                        cnt_d   = cnt_q + 4'd1;
                        frame_d = {1'b1, frame_q[N-1:1]};
                        tx_d    = frame_q[1];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            frame_q <= '1;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised and directed bench for uart_tx_engine; builds one- and two-stop-bit instances
// and checks every line bit against a frame model computed from bit counts.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       ld = 1'b0;
    logic       sh = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] data = 8'h00;
    logic       eight = 1'b1;
    logic       pen = 1'b0;
    logic       ohel = 1'b0;

    logic load1, shift1, shifting1, tx1, rdy1, done1;
    logic load2, shift2, shifting2, tx2, rdy2, done2;
    logic txs, shs, rdys, dns;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign load1  = ld & ~sel;
    assign shift1 = sh & ~sel;
    assign load2  = ld & sel;
    assign shift2 = sh & sel;
    assign txs  = sel ? tx2 : tx1;
    assign shs  = sel ? shifting2 : shifting1;
    assign rdys = sel ? rdy2 : rdy1;
    assign dns  = sel ? done2 : done1;

    uart_tx_engine #(.STOP_BITS(1)) dut1 (
        .clk(clk), .rstb(rstb), .load(load1), .data(data), .eight(eight), .pen(pen),
        .ohel(ohel), .shift(shift1), .shifting(shifting1), .tx(tx1), .tx_rdy(rdy1),
        .done(done1)
    );

    uart_tx_engine #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rstb(rstb), .load(load2), .data(data), .eight(eight), .pen(pen),
        .ohel(ohel), .shift(shift2), .shifting(shifting2), .tx(tx2), .tx_rdy(rdy2),
        .done(done2)
    );

    // Line image from the character rules: start, data LSB first, parity, then stop ones.
    function automatic logic [11:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        int nd;
        int ones;
        logic pb;
        logic [11:0] f;
        nd   = e ? 8 : 7;
        ones = 0;
        f    = '1;
        for (int i = 0; i < nd; i++) ones += int'(d[i]);
        pb   = p ? (((ones + int'(o)) % 2) == 1) : 1'b1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1 + i] = d[i];
        f[1 + nd] = pb;
        return f;
    endfunction

    task automatic run_frame(input logic which, input logic [7:0] d, input logic e,
                             input logic p, input logic o, input int gap,
                             input int mid_load_at, input bit final_load, input string name);
        logic [11:0] exp;
        int nbits;
        exp   = model_frame(d, e, p, o);
        nbits = which ? 12 : 11;
        sel   = which;
        data = d; eight = e; pen = p; ohel = o; ld = 1'b1; sh = 1'b0;
        @(posedge clk); #1;
        ld = 1'b0;
        data = 8'($urandom); eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
        n_cmp++;
        if (txs !== exp[0] || shs !== 1'b1 || rdys !== 1'b0 || dns !== 1'b0) begin
            n_err++;
            $display("FAIL %s start: tx=%b shifting=%b tx_rdy=%b done=%b expected 0 1 0 0",
                     name, txs, shs, rdys, dns);
        end
        for (int k = 1; k <= nbits; k++) begin
            if (k == mid_load_at) begin
                data = 8'h00; ld = 1'b1;
                @(posedge clk); #1;
                ld = 1'b0;
                n_cmp++;
                if (txs !== exp[k-1] || shs !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s mid_load bit%0d: tx=%b shifting=%b expected %b 1",
                             name, k - 1, txs, shs, exp[k-1]);
                end
            end
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
                n_cmp++;
                if (txs !== exp[k-1] || dns !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s hold bit%0d: tx=%b done=%b expected %b 0",
                             name, k - 1, txs, dns, exp[k-1]);
                end
            end
            sh = 1'b1;
            ld = (k == nbits) && final_load;
            if (ld) data = 8'h00;
            @(posedge clk); #1;
            sh = 1'b0; ld = 1'b0;
            n_cmp++;
            if (k < nbits) begin
                if (txs !== exp[k] || shs !== 1'b1 || dns !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s bit%0d: tx=%b shifting=%b done=%b expected %b 1 0",
                             name, k, txs, shs, dns, exp[k]);
                end
            end else begin
                if (txs !== 1'b1 || shs !== 1'b0 || rdys !== 1'b1 || dns !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s end: tx=%b shifting=%b tx_rdy=%b done=%b expected 1 0 1 1",
                             name, txs, shs, rdys, dns);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstb = 1'b1; ld = 1'b1; sh = 1'b1;
        for (int w = 0; w < 2; w++) begin
            sel = 1'(w);
            @(posedge clk); #1;
            n_cmp++;
            if (txs !== 1'b1 || shs !== 1'b0 || rdys !== 1'b1 || dns !== 1'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: tx=%b shifting=%b tx_rdy=%b done=%b expected 1 0 1 0",
                         w + 1, txs, shs, rdys, dns);
            end
        end
        ld = 1'b0; sh = 1'b0; sel = 1'b0;
        rstb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_shift();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sh = 1'b1;
            @(posedge clk); #1;
            sh = 1'b0;
            n_cmp++;
            if (txs !== 1'b1 || shs !== 1'b0 || rdys !== 1'b1 || dns !== 1'b0) begin
                n_err++;
                $display("FAIL idle_shift %0d: tx=%b shifting=%b tx_rdy=%b done=%b expected 1 0 1 0",
                         i, txs, shs, rdys, dns);
            end
        end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        data = 8'h5A; eight = 1'b1; pen = 1'b1; ohel = 1'b0; ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sh = 1'b1;
            @(posedge clk); #1;
            sh = 1'b0;
            @(posedge clk); #1;
        end
        #2 rstb = 1'b1;
        #1;
        n_cmp++;
        if (txs !== 1'b1 || shs !== 1'b0 || rdys !== 1'b1 || dns !== 1'b0) begin
            n_err++;
            $display("FAIL abort_async: tx=%b shifting=%b tx_rdy=%b done=%b expected 1 0 1 0",
                     txs, shs, rdys, dns);
        end
        ld = 1'b1; sh = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (txs !== 1'b1 || shs !== 1'b0 || rdys !== 1'b1) begin
            n_err++;
            $display("FAIL abort_held: tx=%b shifting=%b tx_rdy=%b expected 1 0 1",
                     txs, shs, rdys);
        end
        ld = 1'b0; sh = 1'b0;
        #2 rstb = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, "after_abort");
    endtask

    task automatic test_directed();
        run_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 16, 0, 1'b0, "h55");
        @(posedge clk); #1;
        run_frame(1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, 3, 0, 1'b0, "hA3_even");
        run_frame(1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, "hA3_odd");
        run_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0, "hFF_seven");
        run_frame(1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, "h7F_seven");
    endtask

    task automatic test_ignored_loads();
        run_frame(1'b0, 8'hC6, 1'b1, 1'b1, 1'b1, 2, 5, 1'b1, "mid_and_final_load");
        @(posedge clk); #1;
        n_cmp++;
        if (shs !== 1'b0 || rdys !== 1'b1 || txs !== 1'b1 || dns !== 1'b0) begin
            n_err++;
            $display("FAIL final_load_ignored: shifting=%b tx_rdy=%b tx=%b done=%b expected 0 1 1 0",
                     shs, rdys, txs, dns);
        end
    endtask

    task automatic test_two_stop();
        run_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, "stop2_a");
        run_frame(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, "stop2_b");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_frame(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(1, 4)), (($urandom % 4) == 0) ? 3 : 0,
                      1'($urandom), "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_shift();
        test_directed();
        test_ignored_loads();
        test_abort();
        test_two_stop();
        test_back_to_back();
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter: STOP_BITS, default 1, number of stop bit-times, legal values 1 or 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rstb  input  1  reset, asynchronous, active-high.
REQ-004 Port: load  input  1  one-cycle request to start a frame with data.
REQ-005 Port: data  input  8  character to transmit, LSB first.
REQ-006 Port: eight  input  1  1 = 8 data bits; 0 = 7 data bits, data[7] ignored.
REQ-007 Port: pen  input  1  parity enable.
REQ-008 Port: ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-009 Port: shift  input  1  one-cycle bit-time strobe from the baud counter.
REQ-010 Port: shifting  output  1  high while a frame is in progress; enables the baud counter.
REQ-011 Port: tx  output  1  serial line, idle high, registered.
REQ-012 Port: tx_rdy  output  1  high when idle and able to accept load.
REQ-013 Port: done  output  1  one-cycle pulse when the final stop bit-time ends.

Function
REQ-014 States: IDLE (shifting=0, tx_rdy=1) and SHIFT (shifting=1, tx_rdy=0); no other states.
REQ-015 IDLE->SHIFT on a rising edge with load=1; load in SHIFT is ignored and does not alter the frame.
REQ-016 On accepted load, data, eight, pen and ohel are captured into the frame register in the same edge; later changes to these inputs do not affect the frame.
REQ-017 Frame length N = 11 + (STOP_BITS-1) bit-times, fixed regardless of eight/pen.
REQ-018 Frame order: bit0 start = 0; bits1-7 = data[0..6]; bit8 = eight ? data[7] : P'; bit9 = eight ? P' : 1; bits10..N-1 = 1.
REQ-019 P' = pen ? P : 1, where P = XOR of the captured data bits used (7 or 8) for even parity, inverted when ohel=1.
REQ-020 tx = frame bit 0 (start) from the edge after load; each shift=1 in SHIFT advances tx to the next frame bit at that edge.
REQ-021 Bit counter (4 bits) clears on load, increments on each shift in SHIFT; the N-th shift returns to IDLE: shifting=0, tx_rdy=1, tx=1, done=1 for that one cycle.
REQ-022 shift=1 in IDLE is ignored; counter, tx and outputs unchanged.
REQ-023 load=1 in the same cycle as the N-th shift: return to IDLE only; that load is ignored (tx_rdy was 0).
REQ-024 load on the cycle after done is accepted normally; back-to-back frames have zero idle cycles beyond that.
REQ-025 Counter never exceeds N-1; no wrap-around.

Reset
REQ-026 rstb=1 forces immediately, independent of clk: IDLE, shifting=0, tx_rdy=1, tx=1, done=0, counter=0, frame register all ones.
REQ-027 rstb asserted mid-frame aborts the frame; after release the block is idle and accepts the next load.
REQ-028 load or shift while rstb=1 has no effect.

Verification
REQ-029 Reset, then data=8'h55, eight=1, pen=0, load pulse, 11 shift pulses 16 clocks apart -> tx sequence 0,1,0,1,0,1,0,1,0,1,1; done pulse on the 11th shift; tx_rdy=1 after.
REQ-030 data=8'hA3, eight=1, pen=1, ohel=0 -> bit9 = 0 (even, four ones); repeat with ohel=1 -> bit9 = 1.
REQ-031 data=8'hFF, eight=0, pen=1, ohel=0 -> bits1-7 = 1, bit8 = 1 (seven ones, even parity), bits9-10 = 1; data[7] has no effect.
REQ-032 Second load mid-frame with data=8'h00 -> ignored, original frame completes unchanged; load coincident with final shift -> ignored, tx_rdy rises.
REQ-033 rstb pulsed between clock edges during bit 4 -> tx=1, shifting=0, tx_rdy=1 immediately; next load of 8'h0F transmits a correct full frame.
REQ-034 STOP_BITS=2 build -> 12 shift pulses per frame, bits10-11 = 1, done on the 12th shift.
